// File: rtl/display_pkg.sv
// Shared timing constants, widths and types for the VGA scan-out path.
// 800x600@60 from a 40 MHz pixel clock, with a 400x300 framebuffer upscaled by 2.
package display_pkg;

  localparam int RESOLUTION_X   = 400;
  localparam int RESOLUTION_Y   = 300;
  localparam int PALETTE_LENGTH = 256;
  localparam int COLOR_BITS     = 12;
  localparam int SCALE          = 2;

  localparam int H_ACTIVE = RESOLUTION_X * SCALE;
  localparam int H_FP     = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BP     = 88;
  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 4;
  localparam int V_BP     = 23;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_POL = 1'b1;

  localparam int H_W   = $clog2(H_TOTAL);
  localparam int V_W   = $clog2(V_TOTAL);
  localparam int X_W   = $clog2(RESOLUTION_X);
  localparam int Y_W   = $clog2(RESOLUTION_Y);
  localparam int IDX_W = $clog2(PALETTE_LENGTH);
  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;

  // Compare constants sized to the counters they are compared against.
  localparam logic [H_W-1:0]   H_LAST    = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   H_ACT_END = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]   HS_BEGIN  = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]   HS_END    = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0]   V_LAST    = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   V_ACT_END = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]   VS_BEGIN  = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]   VS_END    = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(SCALE - 1);
  localparam logic [X_W-1:0]   X_LAST    = X_W'(RESOLUTION_X - 1);
  localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(RESOLUTION_Y - 1);

  typedef logic [COLOR_BITS-1:0] rgb_t;
  typedef logic [IDX_W-1:0]      pal_idx_t;

  typedef struct packed {
    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           active;
    logic           hsync;
    logic           vsync;
    logic           sof;
  } timing_t;

endpackage

// File: rtl/display_timing.sv
// Raster counters (T0): beam position, raw syncs, active window and the
// framebuffer read coordinates, derived from sub-pixel counters instead of a divider.
module display_timing
  import display_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  output timing_t        timing,
  output logic [X_W-1:0] fb_rd_x,
  output logic [Y_W-1:0] fb_rd_y
);

  logic [H_W-1:0]   h_cnt;
  logic [V_W-1:0]   v_cnt;
  logic [SUB_W-1:0] h_sub, v_sub;
  logic [X_W-1:0]   x_cnt;
  logic [Y_W-1:0]   y_cnt;
  logic             h_wrap, v_wrap, h_act, v_act, active;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);
  assign h_act  = (h_cnt < H_ACT_END);
  assign v_act  = (v_cnt < V_ACT_END);
  // Reset gates the read strobe at once, since (0,0) itself is an active position.
  assign active = h_act && v_act && !reset;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
      h_sub <= '0;
      v_sub <= '0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      h_sub <= '0;
      x_cnt <= '0;
      if (v_wrap) begin
        v_cnt <= '0;
        v_sub <= '0;
        y_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + V_W'(1);
        if (v_act) begin
          if (v_sub == SUB_LAST) begin
            v_sub <= '0;
            if (y_cnt != Y_LAST) y_cnt <= y_cnt + Y_W'(1);
          end else begin
            v_sub <= v_sub + SUB_W'(1);
          end
        end
      end
    end else begin
      h_cnt <= h_cnt + H_W'(1);
      if (h_act) begin
        if (h_sub == SUB_LAST) begin
          h_sub <= '0;
          if (x_cnt != X_LAST) x_cnt <= x_cnt + X_W'(1);
        end else begin
          h_sub <= h_sub + SUB_W'(1);
        end
      end
    end
  end

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    timing        = '0;
    timing.h_cnt  = h_cnt;
    timing.v_cnt  = v_cnt;
    timing.active = active;
    timing.hsync  = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
    timing.vsync  = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
    timing.sof    = (h_cnt == '0) && (v_cnt == '0);
  end

  assign fb_rd_x = active ? x_cnt : '0;
  assign fb_rd_y = active ? y_cnt : '0;

endmodule

// File: rtl/display_scanout.sv
// Display read path: raster timing, framebuffer fetch, palette lookup and
// output registers, with syncs delayed to stay aligned with rgb (2 clks).
module display_scanout
  import display_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  pal_idx_t       palette_wr_index,
  input  rgb_t           palette_wr_color,
  input  logic           palette_wr_en,
  output logic [X_W-1:0] fb_rd_x,
  output logic [Y_W-1:0] fb_rd_y,
  output logic           fb_rd_en,
  input  pal_idx_t       fb_rd_index,
  output rgb_t           rgb,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic           frame_start,
  output logic           vblank
);

  timing_t timing;
  rgb_t    palette [PALETTE_LENGTH];
  rgb_t    pal_rd;
  logic    active_d1, hsync_d1, vsync_d1, vblank_d1, sof_d1;
  logic    unused_h_cnt;

  display_timing u_timing (
    .clk     (clk),
    .reset   (reset),
    .timing  (timing),
    .fb_rd_x (fb_rd_x),
    .fb_rd_y (fb_rd_y)
  );

  assign fb_rd_en     = timing.active;
  assign unused_h_cnt = ^timing.h_cnt;

  // NOTE: the palette is plain storage and is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (palette_wr_en) palette[palette_wr_index] <= palette_wr_color;
  end

  // Asynchronous read: a same-clock write lands at the edge, after rgb samples the old colour.
  generate
    if ((1 << IDX_W) == PALETTE_LENGTH) begin : g_pow2
      assign pal_rd = palette[fb_rd_index];
    end else begin : g_bounded
      assign pal_rd = (fb_rd_index < IDX_W'(PALETTE_LENGTH)) ? palette[fb_rd_index] : '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_d1   <= 1'b0;
      hsync_d1    <= 1'b0;
      vsync_d1    <= 1'b0;
      vblank_d1   <= 1'b0;
      sof_d1      <= 1'b0;
      rgb         <= '0;
      de          <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      active_d1   <= timing.active;
      hsync_d1    <= timing.hsync;
      vsync_d1    <= timing.vsync;
      vblank_d1   <= (timing.v_cnt >= V_ACT_END);
      sof_d1      <= timing.sof;
      rgb         <= active_d1 ? pal_rd : '0;
      de          <= active_d1;
      hsync       <= hsync_d1 ? SYNC_POL : ~SYNC_POL;
      vsync       <= vsync_d1 ? SYNC_POL : ~SYNC_POL;
      vblank      <= vblank_d1;
      frame_start <= sof_d1;
    end
  end

endmodule
